csr_access_unit: RTL and testbench
==================================

Name: csr_access_unit

Overview:
- Upstream driver of the machine CSR register file. Executes Zicsr instructions: CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI and CSRRCI.
- Accepts one decoded CSR op from execute and runs a read-modify-write sequence over the register file's ren/wen/addr/wdata/rdata port.
- Returns the old CSR value for rd writeback, plus an illegal-instruction flag.
- Holds the pipeline via req_ready while busy.

Parameters:
- XLEN, 32, data width of CSR and GPR values.
- CSR_AW, 12, CSR address width.

Ports:
- CLK  input  1  clock.
- RSTN  input  1  asynchronous active-low reset.
- req_valid  input  1  execute presents a CSR op.
- req_ready  output  1  unit can accept an op.
- req_funct3  input  3  Zicsr funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI).
- req_csr_addr  input  CSR_AW  target CSR.
- req_rs1_idx  input  5  rs1 field; also serves as zimm for the I-forms.
- req_rs1_data  input  XLEN  rs1 register value.
- req_rd_idx  input  5  destination register.
- flush  input  1  pipeline kill.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  writeback accepts the result.
- rsp_rd_idx  output  5  destination register.
- rsp_rd_we  output  1  write rd; 0 when rd is x0 or the op is illegal.
- rsp_rd_data  output  XLEN  old CSR value.
- rsp_illegal  output  1  illegal CSR access.
- csr_ren  output  1  CSR read strobe.
- csr_wen  output  1  CSR write strobe.
- csr_addr  output  CSR_AW  CSR address.
- csr_wdata  output  XLEN  CSR write data.
- csr_rdata  input  XLEN  CSR read data; combinational from the register file.

Behaviour:
- Reset: state IDLE. All registered fields cleared. Outputs at reset: req_ready=1, csr_ren=0, csr_wen=0, csr_addr=0, csr_wdata=0, rsp_valid=0, rsp_rd_idx=0, rsp_rd_we=0, rsp_rd_data=0, rsp_illegal=0.
- Accept: a handshake occurs when req_valid && req_ready, and only in IDLE. The unit latches funct3, addr, rs1_idx, rs1_data and rd_idx.
- Source operand: src = funct3[2] ? zero-extended 5-bit rs1_idx : rs1_data.
- do_read = !(op is RW/RWI && rd_idx==0).
- do_write = RW/RWI always; for RS/RC/RSI/RCI only when rs1_idx!=0.
- Illegal conditions:
  - funct3 is 000 or 100, or
  - do_write && addr[11:10]==2'b11 (read-only space).
- FSM states: IDLE -> RD -> WR -> RSP -> IDLE.
- RD (1 cycle):
  - csr_ren=do_read && !illegal; csr_addr=latched addr.
  - At the clock edge, old_q <= csr_rdata when reading, else 0.
- WR (1 cycle):
  - csr_wen=do_write && !illegal.
  - csr_wdata: RW = src; RS = old_q | src; RC = old_q & ~src.
  - csr_addr is held.
- RSP:
  - rsp_valid=1.
  - rsp_rd_data=old_q, or 0 if illegal.
  - rsp_rd_we=(rd_idx!=0) && !illegal.
  - Outputs are held stable until rsp_ready. On rsp_valid && rsp_ready -> IDLE.
- Latency: accept at edge N; csr_ren high in cycle N+1; csr_wen high in N+2; rsp_valid from N+3. Back-to-back throughput is one op per 4 cycles when rsp_ready=1.
- csr_ren and csr_wen are never high in the same cycle. Neither is high outside RD/WR. csr_addr holds its last value in IDLE.
- flush:
  - In RD or RSP: go to IDLE next cycle, no CSR write, rsp_valid drops.
  - In WR: the write completes, then the unit goes to IDLE without asserting rsp_valid.
  - In IDLE: flush blocks acceptance that cycle; req_ready=0 while flush=1.
- Reset asserted mid-op: immediate return to reset values. No partial write is issued after RSTN rises.
- Write value uses old_q captured in RD; the register file is not re-read in WR.

Optional Feature:
- Macro: CSR_ILLEGAL_CHK_EN.
- Defined:
  - Illegal detection is active as described above.
  - Illegal ops suppress csr_ren, csr_wen and rsp_rd_we, and assert rsp_illegal.
- Undefined:
  - rsp_illegal is tied to 0.
  - funct3 000/100 is treated as RS with do_write=0, i.e. read only.
  - Writes to addr[11:10]==2'b11 are issued normally.
- Timing is identical in both builds.

Test Plan:
- CSRRW x5, 0x340, rs1_data=0xDEADBEEF, CSR mscratch=0x12345678 -> ren in N+1, wen in N+2 with wdata=0xDEADBEEF, rsp_rd_data=0x12345678, rsp_rd_we=1, rd=5.
- CSRRS x6, 0x340, rs1_data=0x0000F000, mscratch=0x00000F0F -> csr_wdata=0x0000FF0F, rsp_rd_data=0x00000F0F. CSRRC with the same values -> wdata=0x00000F0F.
- CSRRSI x7, 0xF14, zimm=0 -> ren=1, wen never asserted, rsp_illegal=0, rsp_rd_data=mhartid. CSRRWI x0, 0x340, zimm=0x1F -> ren never asserted, wdata=0x0000001F, rsp_rd_we=0.
- CSR_ILLEGAL_CHK_EN defined, CSRRW x1, 0xF11, rs1_data=1 -> no ren/wen, rsp_illegal=1, rsp_rd_we=0, rsp_rd_data=0. Undefined, same op -> wen=1 with wdata=1, rsp_illegal=0.
- rsp_ready=0 held for 5 cycles -> rsp_valid and data stable, req_ready=0, no CSR strobes. Then rsp_ready=1 -> IDLE, and the next req_valid is accepted the following cycle.
- flush in RD -> no wen, no rsp_valid, req_ready=1 next cycle. flush in WR -> wen still issued, no rsp_valid. RSTN low in WR -> csr_wen=0 immediately and all outputs return to reset values.

Source files
------------

// File: rtl/csr_access_unit.sv
// Zicsr read-modify-write sequencer driving the machine CSR register file port.
// Optional build macro CSR_ILLEGAL_CHK_EN enables illegal-op detection and suppression.
module csr_access_unit #(
  parameter int XLEN   = 32,
  parameter int CSR_AW = 12
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        req_funct3_i,
  input  logic [CSR_AW-1:0] req_csr_addr_i,
  input  logic [4:0]        req_rs1_idx_i,
  input  logic [XLEN-1:0]   req_rs1_data_i,
  input  logic [4:0]        req_rd_idx_i,
  input  logic              flush_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [4:0]        rsp_rd_idx_o,
  output logic              rsp_rd_we_o,
  output logic [XLEN-1:0]   rsp_rd_data_o,
  output logic              rsp_illegal_o,
  output logic              csr_ren_o,
  output logic              csr_wen_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_e;

  state_e              state_q, state_d;
  logic [2:0]          funct3_q;
  logic [CSR_AW-1:0]   addr_q;
  logic [4:0]          rs1_idx_q;
  logic [XLEN-1:0]     rs1_data_q;
  logic [4:0]          rd_idx_q;
  logic [XLEN-1:0]     old_q, old_d;

  logic                accept;
  logic                is_rw, is_rs, is_rc;
  logic                do_read, do_write, illegal;
  logic                rd_en;
  logic [XLEN-1:0]     src;
  logic [XLEN-1:0]     wdata;

  assign accept = (state_q == IDLE) && req_valid_i && !flush_i;

  // funct3[1:0] selects the operation; funct3[2] selects the immediate source.
  assign is_rw = (funct3_q[1:0] == 2'b01);
  assign is_rs = (funct3_q[1:0] == 2'b10);
  assign is_rc = (funct3_q[1:0] == 2'b11);
  assign src   = funct3_q[2] ? {{(XLEN-5){1'b0}}, rs1_idx_q} : rs1_data_q;

  assign do_read  = !(is_rw && (rd_idx_q == 5'd0));
  assign do_write = is_rw || ((is_rs || is_rc) && (rs1_idx_q != 5'd0));

`ifdef CSR_ILLEGAL_CHK_EN
  logic bad_funct3;
  assign bad_funct3 = (funct3_q[1:0] == 2'b00);
  assign illegal    = bad_funct3 || (do_write && (addr_q[CSR_AW-1 -: 2] == 2'b11));
`else
  // Unknown funct3 falls through to the set path with no write, i.e. a plain read.
  assign illegal = 1'b0;
`endif

  assign rd_en = do_read && !illegal;

  always_comb begin
    wdata = old_q | src;
    if (is_rw) begin
      wdata = src;
    end else if (is_rc) begin
      wdata = old_q & ~src;
    end
  end

  always_comb begin
    state_d       = state_q;
    old_d         = old_q;
    req_ready_o   = 1'b0;
    csr_ren_o     = 1'b0;
    csr_wen_o     = 1'b0;
    csr_wdata_o   = '0;
    rsp_valid_o   = 1'b0;
    rsp_rd_we_o   = 1'b0;
    rsp_rd_data_o = '0;
    rsp_illegal_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = !flush_i;
        if (accept) state_d = RD;
      end
      RD: begin
        csr_ren_o = rd_en;
        old_d     = rd_en ? csr_rdata_i : '0;
        state_d   = flush_i ? IDLE : WR;
      end
      WR: begin
        // A flush here still lets the write land; only the response is dropped.
        csr_wen_o   = do_write && !illegal;
        csr_wdata_o = wdata;
        state_d     = flush_i ? IDLE : RSP;
      end
      RSP: begin
        rsp_valid_o   = 1'b1;
        rsp_rd_data_o = illegal ? '0 : old_q;
        rsp_rd_we_o   = (rd_idx_q != 5'd0) && !illegal;
        rsp_illegal_o = illegal;
        if (flush_i || rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign csr_addr_o   = addr_q;
  assign rsp_rd_idx_o = rd_idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      funct3_q   <= '0;
      addr_q     <= '0;
      rs1_idx_q  <= '0;
      rs1_data_q <= '0;
      rd_idx_q   <= '0;
      old_q      <= '0;
    end else begin
      state_q <= state_d;
      old_q   <= old_d;
      if (accept) begin
        funct3_q   <= req_funct3_i;
        addr_q     <= req_csr_addr_i;
        rs1_idx_q  <= req_rs1_idx_i;
        rs1_data_q <= req_rs1_data_i;
        rd_idx_q   <= req_rd_idx_i;
      end
    end
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed table, hand-written corner
// sequences, and randomized ops against an op-level CSR model.
module tb_csr_access_unit;

  logic        clk;
  logic        rstN;
  logic        reqValid;
  logic        reqReady;
  logic [2:0]  reqFunct3;
  logic [11:0] reqCsrAddr;
  logic [4:0]  reqRs1Idx;
  logic [31:0] reqRs1Data;
  logic [4:0]  reqRdIdx;
  logic        flush;
  logic        rspValid;
  logic        rspReady;
  logic [4:0]  rspRdIdx;
  logic        rspRdWe;
  logic [31:0] rspRdData;
  logic        rspIllegal;
  logic        csrRen;
  logic        csrWen;
  logic [11:0] csrAddr;
  logic [31:0] csrWdata;
  logic [31:0] csrRdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] regFile  [4096];
  logic [31:0] modelCsr [4096];
  logic        preloadEn;
  logic [11:0] preloadAddr;
  logic [31:0] preloadData;

  csr_access_unit #(.XLEN(32), .CSR_AW(12)) dut (
    .clk_i          (clk),
    .rst_ni         (rstN),
    .req_valid_i    (reqValid),
    .req_ready_o    (reqReady),
    .req_funct3_i   (reqFunct3),
    .req_csr_addr_i (reqCsrAddr),
    .req_rs1_idx_i  (reqRs1Idx),
    .req_rs1_data_i (reqRs1Data),
    .req_rd_idx_i   (reqRdIdx),
    .flush_i        (flush),
    .rsp_valid_o    (rspValid),
    .rsp_ready_i    (rspReady),
    .rsp_rd_idx_o   (rspRdIdx),
    .rsp_rd_we_o    (rspRdWe),
    .rsp_rd_data_o  (rspRdData),
    .rsp_illegal_o  (rspIllegal),
    .csr_ren_o      (csrRen),
    .csr_wen_o      (csrWen),
    .csr_addr_o     (csrAddr),
    .csr_wdata_o    (csrWdata),
    .csr_rdata_i    (csrRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural CSR register file: combinational read, clocked write.
  assign csrRdata = regFile[csrAddr];
  always @(posedge clk) begin
    if (preloadEn) regFile[preloadAddr] <= preloadData;
    else if (csrWen) regFile[csrAddr] <= csrWdata;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                               input logic [31:0] rs1d, input logic [4:0] rd);
    reqFunct3  = f3;
    reqCsrAddr = addr;
    reqRs1Idx  = rs1;
    reqRs1Data = rs1d;
    reqRdIdx   = rd;
  endtask

  task automatic preload(input logic [11:0] addr, input logic [31:0] data);
    @(negedge clk);
    preloadEn   = 1'b1;
    preloadAddr = addr;
    preloadData = data;
    @(posedge clk);
    #1 preloadEn = 1'b0;
    modelCsr[addr] = data;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".req_ready"},   reqReady,   1);
    checkOutput({tag, ".csr_ren"},     csrRen,     0);
    checkOutput({tag, ".csr_wen"},     csrWen,     0);
    checkOutput({tag, ".csr_addr"},    csrAddr,    0);
    checkOutput({tag, ".csr_wdata"},   csrWdata,   0);
    checkOutput({tag, ".rsp_valid"},   rspValid,   0);
    checkOutput({tag, ".rsp_rd_idx"},  rspRdIdx,   0);
    checkOutput({tag, ".rsp_rd_we"},   rspRdWe,    0);
    checkOutput({tag, ".rsp_rd_data"}, rspRdData,  0);
    checkOutput({tag, ".rsp_illegal"}, rspIllegal, 0);
  endtask

  // One complete op with rsp_ready held high: accept, RD, WR, RSP.
  task automatic runOp(input string tag, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [4:0] rs1, input logic [31:0] rs1d, input logic [4:0] rd,
                       input logic expRen, input logic expWen, input logic [31:0] expWdata,
                       input logic [31:0] expRdData, input logic expRdWe, input logic expIll);
    @(negedge clk);
    applyStimulus(f3, addr, rs1, rs1d, rd);
    reqValid = 1'b1;
    #1 checkOutput({tag, ".req_ready"}, reqReady, 1);
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput({tag, ".rd_ren"},  csrRen,  expRen);
    checkOutput({tag, ".rd_wen"},  csrWen,  0);
    checkOutput({tag, ".rd_addr"}, csrAddr, addr);
    @(negedge clk);
    checkOutput({tag, ".wr_ren"},  csrRen,  0);
    checkOutput({tag, ".wr_wen"},  csrWen,  expWen);
    checkOutput({tag, ".wr_addr"}, csrAddr, addr);
    if (expWen) checkOutput({tag, ".wr_wdata"}, csrWdata, expWdata);
    @(negedge clk);
    checkOutput({tag, ".rsp_valid"},   rspValid,   1);
    checkOutput({tag, ".rsp_rd_idx"},  rspRdIdx,   rd);
    checkOutput({tag, ".rsp_rd_data"}, rspRdData,  expRdData);
    checkOutput({tag, ".rsp_rd_we"},   rspRdWe,    expRdWe);
    checkOutput({tag, ".rsp_illegal"}, rspIllegal, expIll);
    checkOutput({tag, ".rsp_ren"},     csrRen,     0);
    checkOutput({tag, ".rsp_ready"},   reqReady,   0);
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1;
    logic [31:0] rs1d;
    logic [4:0]  rd;
    logic [31:0] init;
    logic        ren;
    logic        wen;
    logic [31:0] wdata;
    logic [31:0] rdData;
    logic        rdWe;
    logic        ill;
    logic [31:0] after;
  } vec_t;

  vec_t vecs [9];

  // Zicsr semantics at the instruction level, applied to the shadow CSR array.
  task automatic modelOp(input logic [2:0] f3, input logic [11:0] addr, input logic [4:0] rs1,
                         input logic [31:0] rs1d, input logic [4:0] rd,
                         output logic eRen, output logic eWen, output logic [31:0] eWdata,
                         output logic [31:0] eRd, output logic eWe, output logic eIll);
    logic isSwap, isSet, isClear, unknown, writes, reads;
    logic [31:0] operand, seen;
    isSwap  = (f3 == 3'b001) || (f3 == 3'b101);
    isSet   = (f3 == 3'b010) || (f3 == 3'b110);
    isClear = (f3 == 3'b011) || (f3 == 3'b111);
    unknown = (f3 == 3'b000) || (f3 == 3'b100);
    operand = f3[2] ? {27'd0, rs1} : rs1d;
    writes  = isSwap || ((isSet || isClear) && rs1 != 5'd0);
    reads   = !(isSwap && rd == 5'd0);
`ifdef CSR_ILLEGAL_CHK_EN
    eIll = unknown || (writes && addr[11:10] == 2'b11);
`else
    eIll = 1'b0 & unknown;
`endif
    eRen = reads && !eIll;
    seen = eRen ? modelCsr[addr] : 32'd0;
    eWen = writes && !eIll;
    if (isSwap)       eWdata = operand;
    else if (isClear) eWdata = seen & ~operand;
    else              eWdata = seen | operand;
    if (eWen) modelCsr[addr] = eWdata;
    eRd = eIll ? 32'd0 : seen;
    eWe = (rd != 5'd0) && !eIll;
  endtask

  initial begin
    logic [11:0] pool [6];
    logic        eRen, eWen, eWe, eIll;
    logic [31:0] eWdata, eRd;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [4:0]  rs1, rd;
    logic [31:0] rs1d;

    vecs[0] = '{3'b001, 12'h340, 5'd10, 32'hDEADBEEF, 5'd5, 32'h12345678,
                1, 1, 32'hDEADBEEF, 32'h12345678, 1, 0, 32'hDEADBEEF};
    vecs[1] = '{3'b010, 12'h340, 5'd11, 32'h0000F000, 5'd6, 32'h00000F0F,
                1, 1, 32'h0000FF0F, 32'h00000F0F, 1, 0, 32'h0000FF0F};
    vecs[2] = '{3'b011, 12'h340, 5'd11, 32'h0000F000, 5'd6, 32'h00000F0F,
                1, 1, 32'h00000F0F, 32'h00000F0F, 1, 0, 32'h00000F0F};
    vecs[3] = '{3'b110, 12'hF14, 5'd0, 32'hFFFFFFFF, 5'd7, 32'h00000003,
                1, 0, 32'h0, 32'h00000003, 1, 0, 32'h00000003};
    vecs[4] = '{3'b101, 12'h340, 5'd31, 32'h0000AAAA, 5'd0, 32'h00000055,
                0, 1, 32'h0000001F, 32'h0, 0, 0, 32'h0000001F};
`ifdef CSR_ILLEGAL_CHK_EN
    vecs[5] = '{3'b001, 12'hF11, 5'd2, 32'h00000001, 5'd1, 32'h00000ABC,
                0, 0, 32'h0, 32'h0, 0, 1, 32'h00000ABC};
    vecs[6] = '{3'b000, 12'h341, 5'd4, 32'h000000FF, 5'd3, 32'h00000077,
                0, 0, 32'h0, 32'h0, 0, 1, 32'h00000077};
`else
    vecs[5] = '{3'b001, 12'hF11, 5'd2, 32'h00000001, 5'd1, 32'h00000ABC,
                1, 1, 32'h00000001, 32'h00000ABC, 1, 0, 32'h00000001};
    vecs[6] = '{3'b000, 12'h341, 5'd4, 32'h000000FF, 5'd3, 32'h00000077,
                1, 0, 32'h0, 32'h00000077, 1, 0, 32'h00000077};
`endif
    vecs[7] = '{3'b111, 12'h300, 5'd5, 32'h00000000, 5'd9, 32'h0000000F,
                1, 1, 32'h0000000A, 32'h0000000F, 1, 0, 32'h0000000A};
    vecs[8] = '{3'b010, 12'hC00, 5'd0, 32'h0000FFFF, 5'd2, 32'h00001234,
                1, 0, 32'h0, 32'h00001234, 1, 0, 32'h00001234};

    rstN = 1'b0; reqValid = 1'b0; flush = 1'b0; rspReady = 1'b1; preloadEn = 1'b0;
    preloadAddr = '0; preloadData = '0;
    applyStimulus(3'b0, 12'h0, 5'd0, 32'd0, 5'd0);

    repeat (2) @(negedge clk);
    checkResetValues("reset_held");
    rstN = 1'b1;
    @(negedge clk);
    checkResetValues("after_reset");

    $display("[TB] directed table");
    for (int i = 0; i < 9; i++) begin
      preload(vecs[i].addr, vecs[i].init);
      runOp($sformatf("vec%0d", i), vecs[i].f3, vecs[i].addr, vecs[i].rs1, vecs[i].rs1d, vecs[i].rd,
            vecs[i].ren, vecs[i].wen, vecs[i].wdata, vecs[i].rdData, vecs[i].rdWe, vecs[i].ill);
      @(negedge clk);
      checkOutput($sformatf("vec%0d.csr_after", i), regFile[vecs[i].addr], vecs[i].after);
      modelCsr[vecs[i].addr] = vecs[i].after;
    end

    $display("[TB] backpressure");
    preload(12'h341, 32'hCAFEF00D);
    rspReady = 1'b0;
    @(negedge clk);
    applyStimulus(3'b010, 12'h341, 5'd0, 32'd0, 5'd12);
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp.rsp_valid", rspValid,  1);
      checkOutput("bp.rd_data",   rspRdData, 32'hCAFEF00D);
      checkOutput("bp.rd_idx",    rspRdIdx,  12);
      checkOutput("bp.req_ready", reqReady,  0);
      checkOutput("bp.strobes",   {csrRen, csrWen}, 0);
    end
    rspReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp.idle_valid", rspValid, 0);
    checkOutput("bp.idle_ready", reqReady, 1);
    applyStimulus(3'b010, 12'h341, 5'd0, 32'd0, 5'd13);
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    checkOutput("bp.next_ren", csrRen, 1);
    repeat (2) @(negedge clk);
    checkOutput("bp.next_rd_data", rspRdData, 32'hCAFEF00D);
    checkOutput("bp.next_rd_idx",  rspRdIdx,  13);

    $display("[TB] flush in RD");
    preload(12'h340, 32'h11112222);
    @(negedge clk);
    applyStimulus(3'b001, 12'h340, 5'd3, 32'h00000099, 5'd4);
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    flush = 1'b1;
    #1 checkOutput("flrd.ren", csrRen, 1);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flrd.wen",       csrWen,   0);
    checkOutput("flrd.rsp_valid", rspValid, 0);
    checkOutput("flrd.req_ready", reqReady, 1);
    @(negedge clk);
    checkOutput("flrd.rsp_valid2", rspValid, 0);
    checkOutput("flrd.csr_kept",   regFile[12'h340], 32'h11112222);

    $display("[TB] flush in WR");
    @(negedge clk);
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    checkOutput("flwr.wen",   csrWen,   1);
    checkOutput("flwr.wdata", csrWdata, 32'h00000099);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    checkOutput("flwr.rsp_valid", rspValid, 0);
    checkOutput("flwr.req_ready", reqReady, 1);
    checkOutput("flwr.csr_written", regFile[12'h340], 32'h00000099);
    modelCsr[12'h340] = 32'h00000099;

    $display("[TB] flush in IDLE");
    @(negedge clk);
    flush = 1'b1;
    applyStimulus(3'b010, 12'h340, 5'd0, 32'd0, 5'd6);
    reqValid = 1'b1;
    #1 checkOutput("flidle.req_ready", reqReady, 0);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    reqValid = 1'b0;
    checkOutput("flidle.no_accept", csrRen, 0);
    #1 checkOutput("flidle.req_ready2", reqReady, 1);

    $display("[TB] reset in WR");
    preload(12'h340, 32'h5555AAAA);
    @(negedge clk);
    applyStimulus(3'b001, 12'h340, 5'd3, 32'h00000012, 5'd8);
    reqValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    @(negedge clk);
    checkOutput("rstwr.wen_before", csrWen, 1);
    rstN = 1'b0;
    #1 checkResetValues("rstwr");
    @(posedge clk);
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checkOutput("rstwr.csr_kept", regFile[12'h340], 32'h5555AAAA);
    checkOutput("rstwr.wen_after", csrWen, 0);
    checkOutput("rstwr.valid_after", rspValid, 0);

    $display("[TB] randomized ops");
    pool = '{12'h340, 12'h341, 12'h300, 12'hF11, 12'hC01, 12'h7C0};
    for (int i = 0; i < 6; i++) preload(pool[i], $urandom);
    for (int i = 0; i < 40; i++) begin
      f3   = 3'($urandom_range(0, 7));
      addr = pool[$urandom_range(0, 5)];
      rs1  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rd   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1d = $urandom;
      modelOp(f3, addr, rs1, rs1d, rd, eRen, eWen, eWdata, eRd, eWe, eIll);
      runOp($sformatf("rnd%0d", i), f3, addr, rs1, rs1d, rd, eRen, eWen, eWdata, eRd, eWe, eIll);
      @(negedge clk);
      checkOutput($sformatf("rnd%0d.csr_after", i), regFile[addr], modelCsr[addr]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
